pc_tile_buffer_ctrl: RTL
========================

// Module: pc_tile_buffer_ctrl
// PURPOSE
//  Parametrised line buffer in front of the mul-tree datapath.
//  - FILL: captures a programmable number of IN_W-bit input lines into an inferred BRAM.
//  - DRAIN: replays each line as SLICES = IN_W/SLICE_W slices over a valid/ready stream
//    that supports backpressure.
//  - Independently tracks the max bf16 exponent over each node's result beats (fully pipelined, no stall).
// PARAMETERS
//  IN_W       256  input line width; must be a multiple of SLICE_W
//  SLICE_W    128  output slice width
//  DEPTH      256  BRAM lines
//  AW         $clog2(DEPTH)  address width
//  RES_LANES  4    bf16 lanes per result beat
//  CNT_W      11   result-beat counter width
// PORTS
//  clk          in   1               clock
//  rst          in   1               synchronous, active-high reset
//  in_data      in   IN_W            input line
//  in_vld       in   1               input valid
//  in_ready     out  1               input ready; registered
//  fill_len     in   AW+1            lines per fill; 0 => DEPTH
//  out_slice    out  SLICE_W         slice to datapath
//  out_vld      out  1               slice valid
//  out_ready    in   1               datapath accepts slice
//  state        out  2               0=FILL, 1=DRAIN (2,3 unused)
//  res_data     in   RES_LANES*16    bf16 results; lane k = [16k+15:16k], exponent = [16k+14:16k+7]
//  res_vld      in   1               result beat valid
//  node_len_m1  in   CNT_W           result beats per node minus one
//  max_exp      out  8               max exponent of the last completed node
//  max_exp_vld  out  1               1-cycle pulse
// BEHAVIOUR
//  Reset values: state=FILL, in_ready=1, out_vld=0, max_exp=0, max_exp_vld=0.
//    wr_ptr, rd_ptr, slice_idx, beat counter, running max and exponent pipeline all clear to 0.
//  Reset mid-operation: fill/drain is abandoned, BRAM contents are don't-care, and any partial node max is discarded.
//  FILL:
//    - fill_len is latched on the cycle wr_ptr==0 and state==FILL.
//    - Each accept (in_vld & in_ready) writes BRAM[wr_ptr] and increments wr_ptr.
//    - An accept at wr_ptr == len-1 clears wr_ptr to 0, sets state=DRAIN and drops in_ready next cycle.
//  DRAIN:
//    - BRAM read latency is 1 cycle. Output data is held in the BRAM output register.
//    - out_slice = q[slice_idx*SLICE_W +: SLICE_W]; slice 0 (LSBs) is emitted first.
//    - A read of rd_ptr issues on the DRAIN entry cycle and on every cycle where the last slice of a line is accepted.
//    - First out_vld occurs 2 cycles after the final write is accepted.
//    - Sustained throughput is 1 slice/cycle with no bubble between lines.
//    - While out_vld=1 and out_ready=0, out_slice and out_vld hold stable; out_vld never drops before acceptance.
//    - Accepting the last slice of line len-1: next cycle state=FILL, in_ready=1, out_vld=0, rd_ptr=0, slice_idx=0.
//    - in_vld is ignored in DRAIN; out_ready is ignored in FILL.
//  Max exponent (independent of state):
//    - S1 registers the max of the lane exponents, the beat-valid flag and a last flag (cnt==node_len_m1).
//      The beat counter increments per res_vld and wraps to 0 on the last beat.
//    - S2 updates acc <= last ? 0 : max(acc, S1 max).
//      On last it also sets max_exp <= max(acc, S1 max) and max_exp_vld=1 for 1 cycle.
//    - max_exp_vld fires exactly 2 cycles after the final beat; max_exp holds until the next node completes.
//    - Back-to-back nodes with no gap are supported: the first beat of node n+1 never merges into node n.
//    - node_len_m1=0 gives one pulse per beat. node_len_m1 changes are only legal between nodes.
//    - Compares are unsigned 8-bit.
// CONFIGURATION
//  `PCBUF_EXP_SKIP_SPECIAL_EN` defined:
//    - Lanes with exponent 8'hFF (Inf/NaN) contribute 0 to the max.
//    - A node consisting only of specials reports 0.
//  Not defined: all lanes compare as raw exponents, so 8'hFF can win.
// TESTING
//  1. Reset, fill_len=4, 4 lines L0..L3 with in_vld held high.
//     -> in_ready low after the 4th accept; 8 slices L0[127:0], L0[255:128], ... L3[255:128].
//     -> out_ready=1 gives 8 consecutive valid cycles; first valid 2 cycles after the last write.
//  2. DRAIN with out_ready toggled 1,0,0,1,...
//     -> out_slice is stable across stalls; no slice is lost or duplicated; state returns to FILL after the 8th accept.
//  3. fill_len=0, DEPTH=256: write 256 lines of the address pattern.
//     -> wr_ptr wraps to 0 and DRAIN starts; 512 slices out in order.
//     -> A second fill round repeats identically.
//  4. node_len_m1=2, beats with max exponents 0x7F, 0x85, 0x80, then 0x10, 0x11, 0x12 back-to-back.
//     -> Pulses of 0x85 then 0x12, each 2 cycles after its final beat.
//  5. One beat with a lane exponent of 0xFF and other lanes 0x90, node_len_m1=0.
//     -> max_exp = 0x90 with the macro defined, 0xFF without.
//  6. Assert rst mid-DRAIN and mid-node.
//     -> Next cycle: state=FILL, in_ready=1, out_vld=0, no max_exp_vld.
//     -> The next node's max excludes all pre-reset beats.

Source files
------------

// File: rtl/pc_tile_buffer_ctrl.sv
// Line buffer in front of the mul-tree: fills IN_W-bit lines into block RAM, drains them as SLICE_W slices,
// and tracks the max bf16 exponent per result node. Define PCBUF_EXP_SKIP_SPECIAL_EN to exclude 8'hFF exponents.
module pc_tile_buffer_ctrl #(
    parameter int IN_W      = 256,
    parameter int SLICE_W   = 128,
    parameter int DEPTH     = 256,
    parameter int AW        = $clog2(DEPTH),
    parameter int RES_LANES = 4,
    parameter int CNT_W     = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IN_W-1:0]          in_data,
    input  logic                     in_vld,
    output logic                     in_ready,
    input  logic [AW:0]              fill_len,
    output logic [SLICE_W-1:0]       out_slice,
    output logic                     out_vld,
    input  logic                     out_ready,
    output logic [1:0]               state,
    input  logic [RES_LANES*16-1:0]  res_data,
    input  logic                     res_vld,
    input  logic [CNT_W-1:0]         node_len_m1,
    output logic [7:0]               max_exp,
    output logic                     max_exp_vld
);
    localparam int SLICES = IN_W / SLICE_W;
    localparam int SW     = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [AW-1:0]    ONE_A     = 1;
    localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [SW-1:0]    ONE_S     = 1;
    localparam logic [SW-1:0]    LAST_S    = SW'(SLICES - 1);
    localparam logic [CNT_W-1:0] ONE_C     = 1;

    typedef enum logic [1:0] {ST_FILL = 2'd0, ST_DRAIN = 2'd1} state_t;

    state_t            state_q;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q, len_m1_q;
    logic [SW-1:0]     slice_idx_q;
    logic              in_ready_q, out_vld_q, entry_q;
    logic [IN_W-1:0]   mem [DEPTH];
    logic [IN_W-1:0]   rd_data_q;

    logic [AW-1:0]     fill_len_m1, len_m1_cur, rd_addr;
    logic              accept_in, accept_out, last_slice, line_done, drain_done, rd_en;

    // fill_len==0 selects the full depth
    assign fill_len_m1 = (fill_len == '0) ? LAST_ADDR : fill_len[AW-1:0] - ONE_A;
    assign len_m1_cur  = (wr_ptr_q == '0) ? fill_len_m1 : len_m1_q;
    assign accept_in   = (state_q == ST_FILL) && in_vld && in_ready_q;
    assign accept_out  = (state_q == ST_DRAIN) && out_vld_q && out_ready;
    assign last_slice  = (slice_idx_q == LAST_S);
    assign line_done   = accept_out && last_slice;
    assign drain_done  = line_done && (rd_ptr_q == len_m1_q);
    // Prefetch the next line while its predecessor's last slice is taken, so lines flow without a bubble
    assign rd_en       = entry_q || (line_done && !drain_done);
    assign rd_addr     = entry_q ? rd_ptr_q : rd_ptr_q + ONE_A;

    always_ff @(posedge clk) begin
        if (accept_in)
            mem[wr_ptr_q] <= in_data;
        if (rd_en)
            rd_data_q <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FILL;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            len_m1_q    <= '0;
            slice_idx_q <= '0;
            in_ready_q  <= 1'b1;
            out_vld_q   <= 1'b0;
            entry_q     <= 1'b0;
        end else begin
            entry_q <= 1'b0;
            case (state_q)
                ST_FILL: begin
                    if (wr_ptr_q == '0)
                        len_m1_q <= fill_len_m1;
                    if (accept_in) begin
                        if (wr_ptr_q == len_m1_cur) begin
                            wr_ptr_q   <= '0;
                            state_q    <= ST_DRAIN;
                            in_ready_q <= 1'b0;
                            entry_q    <= 1'b1;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + ONE_A;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (entry_q)
                        out_vld_q <= 1'b1;
                    if (accept_out) begin
                        if (last_slice) begin
                            slice_idx_q <= '0;
                            if (drain_done) begin
                                state_q    <= ST_FILL;
                                in_ready_q <= 1'b1;
                                out_vld_q  <= 1'b0;
                                rd_ptr_q   <= '0;
                            end else begin
                                rd_ptr_q <= rd_ptr_q + ONE_A;
                            end
                        end else begin
                            slice_idx_q <= slice_idx_q + ONE_S;
                        end
                    end
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end

    logic [SLICE_W-1:0] slice_w [SLICES];
    logic [7:0]         lane_exp [RES_LANES];

    for (genvar gi = 0; gi < SLICES; gi++) begin : g_slice
        assign slice_w[gi] = rd_data_q[gi*SLICE_W +: SLICE_W];
    end

    for (genvar gi = 0; gi < RES_LANES; gi++) begin : g_lane
`ifdef PCBUF_EXP_SKIP_SPECIAL_EN
        assign lane_exp[gi] = (res_data[16*gi+7 +: 8] == 8'hFF) ? 8'h00 : res_data[16*gi+7 +: 8];
`else
        assign lane_exp[gi] = res_data[16*gi+7 +: 8];
`endif
    end

    assign out_slice   = slice_w[slice_idx_q];
    assign out_vld     = out_vld_q;
    assign in_ready    = in_ready_q;
    assign state       = state_q;

    // Sign and mantissa bits do not take part in the exponent max
    logic unused_res_bits;
    assign unused_res_bits = ^res_data;

    logic [7:0]       beat_max, s1_max_q, acc_q, merged, max_exp_q;
    logic [CNT_W-1:0] cnt_q;
    logic             beat_last, s1_vld_q, s1_last_q, max_exp_vld_q;

    always_comb begin
        beat_max = 8'h00;
        for (int k = 0; k < RES_LANES; k++)
            if (lane_exp[k] > beat_max)
                beat_max = lane_exp[k];
    end

    assign beat_last = (cnt_q == node_len_m1);
    assign merged    = (s1_max_q > acc_q) ? s1_max_q : acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            s1_max_q      <= 8'h00;
            s1_vld_q      <= 1'b0;
            s1_last_q     <= 1'b0;
            acc_q         <= 8'h00;
            max_exp_q     <= 8'h00;
            max_exp_vld_q <= 1'b0;
        end else begin
            if (res_vld)
                cnt_q <= beat_last ? '0 : cnt_q + ONE_C;
            s1_max_q      <= beat_max;
            s1_vld_q      <= res_vld;
            s1_last_q     <= res_vld && beat_last;
            max_exp_vld_q <= s1_vld_q && s1_last_q;
            // Clearing acc on the last beat keeps the next node's first beat from merging into this one
            if (s1_vld_q) begin
                if (s1_last_q) begin
                    acc_q     <= 8'h00;
                    max_exp_q <= merged;
                end else begin
                    acc_q <= merged;
                end
            end
        end
    end

    assign max_exp     = max_exp_q;
    assign max_exp_vld = max_exp_vld_q;
endmodule
